mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max memory wait cycles (1..255) before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction[5:0] from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU result equals zero.
REQ-007 SHALL have port mem_ready  input  1  unified memory access complete this cycle.
REQ-008 SHALL have outputs mem_req, mem_we, iord, ir_write, pc_en, reg_we, mem_to_reg, alu_src_a  output  1 each  datapath strobes and selects.
REQ-009 SHALL have outputs reg_dst[1:0] (00 rt, 01 rd, 10 r31), alu_src_b[1:0] (00 B, 01 const 4, 10 imm, 11 imm<<2), pc_src[1:0] (00 ALU, 01 ALUOut, 10 jump target, 11 rs), alu_op[2:0] (000 add, 001 sub, 010 funct).
REQ-010 SHALL have outputs state[3:0] (current state) and illegal_op, mem_err  output  1 each.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12, JR=13.
REQ-012 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00; ir_write and pc_en SHALL be 1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000 (branch target to ALUOut), then dispatch: lw(100011)/sw(101011)->MEMADR, R-type(000000)->EXEC, beq(000100)/bne(000101)->BRANCH, addi(001000)->ADDIEX, j(000010)->JUMP.
REQ-014 Unlisted opcode in DECODE SHALL pulse illegal_op for exactly that cycle and return to FETCH with no register or memory write.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000; next MEMRD for lw, MEMWR for sw.
REQ-016 MEMRD SHALL drive mem_req=1, iord=1, advancing to MEMWB on mem_ready; MEMWR SHALL drive mem_req=1, iord=1, mem_we=1, advancing to FETCH on mem_ready.
REQ-017 MEMWB SHALL drive reg_we=1, reg_dst=00, mem_to_reg=1, then FETCH.
REQ-018 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, then ALUWB; ALUWB SHALL drive reg_we=1, reg_dst=01, mem_to_reg=0, then FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_en=(beq&zero)|(bne&~zero), then FETCH.
REQ-020 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, then ADDIWB; ADDIWB SHALL drive reg_we=1, reg_dst=00, mem_to_reg=0, then FETCH.
REQ-021 JUMP SHALL drive pc_src=10, pc_en=1, then FETCH.
REQ-022 Outputs not named for a state SHALL be 0 in that state.
REQ-023 Latency with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles.
REQ-024 An 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR, increment each cycle mem_req=1 and mem_ready=0, and on reaching MEM_TIMEOUT SHALL force FETCH, set sticky mem_err, and suppress pc_en, ir_write, reg_we and mem_we in that cycle.
REQ-025 mem_ready when mem_req=0 SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, clear wait counter and mem_err, and hold every output at 0, independent of clk.
REQ-027 Reset mid-operation (any state, incl. mid-wait) SHALL abort without any write; the first cycle after reset=1 SHALL be FETCH with mem_req=1.

Configuration
REQ-028 Macro MIPS_MC_CTRL_JAL_EN defined: jal (000011) SHALL go DECODE->JAL driving reg_we=1, reg_dst=10, mem_to_reg=0, pc_src=10, pc_en=1, then FETCH; R-type with funct 001000 (jr) SHALL go EXEC->JR driving pc_src=11, pc_en=1, reg_we=0, then FETCH.
REQ-029 Macro undefined: states JAL/JR SHALL not exist, jal SHALL be treated as illegal per REQ-014, and funct 001000 SHALL execute as an ordinary R-type.

Verification
REQ-030 lw, mem_ready=1 -> states 0,1,2,3,4,0; reg_we=1, mem_to_reg=1 only in cycle 5.
REQ-031 beq, zero=1 then bne, zero=1 -> pc_en=1 in BRANCH for beq, 0 for bne; both return to FETCH after 3 cycles.
REQ-032 mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles, state=0, no ir_write/pc_en pulses.
REQ-033 opcode 111111 -> illegal_op high exactly 1 cycle in DECODE, reg_we and mem_we never asserted.
REQ-034 reset driven 0 mid MEMWR wait -> state=0 and mem_we=0 before next clk edge; mem_err=0.
REQ-035 With MIPS_MC_CTRL_JAL_EN: jal -> reg_dst=10, reg_we=1, pc_en=1 in JAL; without: jal -> illegal_op pulse.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with a shared-memory wait timeout and sticky mem_err.
// Define MIPS_MC_CTRL_JAL_EN to add the jal / jr states (JAL=12, JR=13).
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic       reg_we,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] reg_dst,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_op,
   output logic [3:0] state,
   output logic       illegal_op,
   output logic       mem_err
);

`ifdef MIPS_MC_CTRL_JAL_EN
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
      S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8, S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10, S_JUMP = 4'd11, S_JAL = 4'd12, S_JR = 4'd13
   } state_t;
`else
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
      S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7, S_BRANCH = 4'd8, S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10, S_JUMP = 4'd11
   } state_t;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       mem_err_q, mem_err_d;
   logic       mem_phase_s, timeout_s;
   logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_en_s, reg_we_s, mem_to_reg_s, alu_src_a_s;
   logic       illegal_op_s;
   logic [1:0] reg_dst_s, alu_src_b_s, pc_src_s;
   logic [2:0] alu_op_s;

`ifndef MIPS_MC_CTRL_JAL_EN
   logic unused_funct_s;
   assign unused_funct_s = ^funct;
`endif

   // The wait that would make the counter reach MEM_TIMEOUT is the aborting cycle.
   assign mem_phase_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout_s   = mem_phase_s && !mem_ready && (wait_q == TIMEOUT_M1);

   // State, wait counter and sticky error register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      state_d      = state_q;
      mem_err_d    = mem_err_q;
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      iord_s       = 1'b0;
      ir_write_s   = 1'b0;
      pc_en_s      = 1'b0;
      reg_we_s     = 1'b0;
      mem_to_reg_s = 1'b0;
      alu_src_a_s  = 1'b0;
      illegal_op_s = 1'b0;
      reg_dst_s    = 2'b00;
      alu_src_b_s  = 2'b00;
      pc_src_s     = 2'b00;
      alu_op_s     = 3'b000;
      case (state_q)
         S_FETCH: begin
            mem_req_s   = 1'b1;
            alu_src_b_s = 2'b01;
            if (timeout_s) begin
               mem_err_d = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               ir_write_s = 1'b1;
               pc_en_s    = 1'b1;
               state_d    = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b_s = 2'b11;
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_RTYPE:       state_d = S_EXEC;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_J:           state_d = S_JUMP;
`ifdef MIPS_MC_CTRL_JAL_EN
               6'b000011:      state_d = S_JAL;
`endif
               default: begin
                  illegal_op_s = 1'b1;
                  state_d      = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            if (opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            if (timeout_s) begin
               mem_err_d = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               state_d = S_MEMWB;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMWR: begin
            mem_req_s = 1'b1;
            iord_s    = 1'b1;
            mem_we_s  = !timeout_s;
            if (timeout_s) begin
               mem_err_d = 1'b1;
               state_d   = S_FETCH;
            end else if (mem_ready) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_MEMWB: begin
            reg_we_s     = 1'b1;
            mem_to_reg_s = 1'b1;
            state_d      = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a_s = 1'b1;
            alu_op_s    = 3'b010;
`ifdef MIPS_MC_CTRL_JAL_EN
            if (funct == 6'b001000) begin
               state_d = S_JR;
            end else begin
               state_d = S_ALUWB;
            end
`else
            state_d = S_ALUWB;
`endif
         end
         S_ALUWB: begin
            reg_we_s  = 1'b1;
            reg_dst_s = 2'b01;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_s = 1'b1;
            alu_op_s    = 3'b001;
            pc_src_s    = 2'b01;
            pc_en_s     = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            state_d     = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_we_s = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_s = 2'b10;
            pc_en_s  = 1'b1;
            state_d  = S_FETCH;
         end
`ifdef MIPS_MC_CTRL_JAL_EN
         S_JAL: begin
            reg_we_s  = 1'b1;
            reg_dst_s = 2'b10;
            pc_src_s  = 2'b10;
            pc_en_s   = 1'b1;
            state_d   = S_FETCH;
         end
         S_JR: begin
            pc_src_s = 2'b11;
            pc_en_s  = 1'b1;
            state_d  = S_FETCH;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if ((state_d != state_q) || timeout_s) begin
         wait_d = 8'd0;
      end else if (mem_req_s && !mem_ready) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // Reset blanks every strobe at once, without waiting for a clock.
   assign mem_req    = reset & mem_req_s;
   assign mem_we     = reset & mem_we_s;
   assign iord       = reset & iord_s;
   assign ir_write   = reset & ir_write_s;
   assign pc_en      = reset & pc_en_s;
   assign reg_we     = reset & reg_we_s;
   assign mem_to_reg = reset & mem_to_reg_s;
   assign alu_src_a  = reset & alu_src_a_s;
   assign illegal_op = reset & illegal_op_s;
   assign reg_dst    = reset ? reg_dst_s : 2'b00;
   assign alu_src_b  = reset ? alu_src_b_s : 2'b00;
   assign pc_src     = reset ? pc_src_s : 2'b00;
   assign alu_op     = reset ? alu_op_s : 3'b000;
   assign state      = state_q;
   assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl (MEM_TIMEOUT=4); expected output
// vectors are queued as stimulus is driven and compared at the falling edge.
module tb_mips_multicycle_ctrl;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       mem_req, mem_we, iord, ir_write, pc_en, reg_we, mem_to_reg, alu_src_a;
   logic [1:0] reg_dst, alu_src_b, pc_src;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic       illegal_op, mem_err;

   int tests_run = 0;
   int tests_failed = 0;
   logic [22:0] exp_q[$];
   logic [22:0] exp_v;
   logic [22:0] obs;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_en(pc_en), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .reg_dst(reg_dst), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_op(alu_op), .state(state), .illegal_op(illegal_op), .mem_err(mem_err)
   );

   assign obs = {state, mem_req, mem_we, iord, ir_write, pc_en, reg_we, mem_to_reg, alu_src_a,
                 reg_dst, alu_src_b, pc_src, alu_op, illegal_op, mem_err};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // strb = {mem_req, mem_we, iord, ir_write, pc_en, reg_we, mem_to_reg, alu_src_a}
   function automatic logic [22:0] mk(input logic [3:0] st, input logic [7:0] strb,
                                      input logic [1:0] rd, input logic [1:0] sb,
                                      input logic [1:0] ps, input logic [2:0] op,
                                      input logic ill, input logic err);
      return {st, strb, rd, sb, ps, op, ill, err};
   endfunction

   function automatic logic [22:0] f_fetch(input logic rdy, input logic err);
      return mk(4'd0, rdy ? 8'b1001_1000 : 8'b1000_0000, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0, err);
   endfunction

   function automatic logic [22:0] f_decode(input logic ill, input logic err);
      return mk(4'd1, 8'b0000_0000, 2'b00, 2'b11, 2'b00, 3'b000, ill, err);
   endfunction

   task automatic test_reset();
      reset = 1'b0; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
      #2;
      exp_q.push_back(23'd0);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_hold: got %h, expected %h", obs, exp_v);
      end
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = 1'b0;
      exp_q.push_back(f_fetch(1'b0, 1'b0));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_release: got %h, expected %h", obs, exp_v);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_store();
      logic [22:0] seq [5];
      int n;
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'b100011 : 6'b101011;
         seq[0] = f_fetch(1'b1, 1'b0);
         seq[1] = f_decode(1'b0, 1'b0);
         seq[2] = mk(4'd2, 8'b0000_0001, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
         if (k == 0) begin
            seq[3] = mk(4'd3, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
            seq[4] = mk(4'd4, 8'b0000_0110, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
            n = 5;
         end else begin
            seq[3] = mk(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
            n = 4;
         end
         mem_ready = 1'b1;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
               tests_failed++;
               $display("FAIL %s step %0d: got %h, expected %h", (k == 0) ? "lw" : "sw", i, obs, exp_v);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_rtype();
      logic [22:0] seq [4];
      for (int k = 0; k < 2; k++) begin
         opcode = 6'b000000;
         funct  = (k == 0) ? 6'b100000 : 6'b001000;
         mem_ready = 1'b1;
         seq[0] = f_fetch(1'b1, 1'b0);
         seq[1] = f_decode(1'b0, 1'b0);
         seq[2] = mk(4'd6, 8'b0000_0001, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
         seq[3] = mk(4'd7, 8'b0000_0100, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
`ifdef MIPS_MC_CTRL_JAL_EN
         if (k == 1) begin
            seq[3] = mk(4'd13, 8'b0000_1000, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b0);
         end
`endif
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back(seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
               tests_failed++;
               $display("FAIL rtype funct=%b step %0d: got %h, expected %h", funct, i, obs, exp_v);
            end
            @(posedge clk); #1;
         end
      end
      funct = 6'd0;
   endtask

   task automatic test_addi_jump();
      logic [22:0] seq [4];
      int n;
      for (int k = 0; k < 2; k++) begin
         mem_ready = 1'b1;
         seq[0] = f_fetch(1'b1, 1'b0);
         seq[1] = f_decode(1'b0, 1'b0);
         if (k == 0) begin
            opcode = 6'b001000;
            seq[2] = mk(4'd9, 8'b0000_0001, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
            seq[3] = mk(4'd10, 8'b0000_0100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
            n = 4;
         end else begin
            opcode = 6'b000010;
            seq[2] = mk(4'd11, 8'b0000_1000, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
            n = 3;
         end
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
               tests_failed++;
               $display("FAIL %s step %0d: got %h, expected %h", (k == 0) ? "addi" : "j", i, obs, exp_v);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_branch();
      logic [22:0] seq [3];
      logic [5:0] ops [4] = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
      logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic       tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         opcode = ops[k]; zero = zs[k]; mem_ready = 1'b1;
         seq[0] = f_fetch(1'b1, 1'b0);
         seq[1] = f_decode(1'b0, 1'b0);
         seq[2] = mk(4'd8, {4'b0000, tk[k], 3'b001}, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0);
         for (int i = 0; i < 3; i++) begin
            exp_q.push_back(seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
               tests_failed++;
               $display("FAIL branch op=%b zero=%b step %0d: got %h, expected %h", ops[k], zs[k], i, obs, exp_v);
            end
            @(posedge clk); #1;
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [22:0] seq [3];
      int n;
      for (int k = 0; k < 2; k++) begin
         mem_ready = 1'b1;
         opcode = (k == 0) ? 6'b111111 : 6'b000011;
         seq[0] = f_fetch(1'b1, 1'b0);
         seq[1] = f_decode(1'b1, 1'b0);
         n = 2;
`ifdef MIPS_MC_CTRL_JAL_EN
         if (k == 1) begin
            seq[1] = f_decode(1'b0, 1'b0);
            seq[2] = mk(4'd12, 8'b0000_1100, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
            n = 3;
         end
`endif
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
               tests_failed++;
               $display("FAIL %s step %0d: got %h, expected %h", (k == 0) ? "illegal" : "jal", i, obs, exp_v);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_timeout();
      logic [22:0] seq [6];
      logic        rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'b111111;
      for (int i = 0; i < 4; i++) seq[i] = f_fetch(1'b0, 1'b0);
      seq[4] = f_fetch(1'b1, 1'b1);
      seq[5] = f_decode(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL fetch_timeout step %0d: got %h, expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_write_timeout();
      logic [22:0] seq [7];
      logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      opcode = 6'b101011;
      seq[0] = f_fetch(1'b1, 1'b1);
      seq[1] = f_decode(1'b0, 1'b1);
      seq[2] = mk(4'd2, 8'b0000_0001, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b1);
      for (int i = 3; i < 6; i++) seq[i] = mk(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      seq[6] = mk(4'd5, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL write_timeout step %0d: got %h, expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_write();
      logic [22:0] seq [4];
      logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 6'b101011;
      seq[0] = f_fetch(1'b1, 1'b1);
      seq[1] = f_decode(1'b0, 1'b1);
      seq[2] = mk(4'd2, 8'b0000_0001, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b1);
      seq[3] = mk(4'd5, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i];
         exp_q.push_back(seq[i]);
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_write step %0d: got %h, expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      exp_q.push_back(23'd0);
      exp_q.push_back(23'd0);
      exp_q.push_back(f_fetch(1'b0, 1'b0));
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_async: got %h, expected %h", obs, exp_v);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_held: got %h, expected %h", obs, exp_v);
      end
      reset = 1'b1;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_restart: got %h, expected %h", obs, exp_v);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_rtype();
      test_addi_jump();
      test_branch();
      test_illegal();
      test_timeout();
      test_write_timeout();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
